// File: rtl/game_pkg.sv
// Shared types and constants for the game state manager.
//   game_state_e : 2-bit game progression state (IDLE, PLAY, DYING, GAME_OVER)
//   TIMER_W      : width of the frame down-counters
//   timer_next   : next-count rule shared by frame_timer and the top, so the
//                  top can register outputs that depend on the next count.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAY      = 2'd1,
        ST_DYING     = 2'd2,
        ST_GAME_OVER = 2'd3
    } game_state_e;

    localparam int TIMER_W           = 7;
    localparam int LIVES_INIT_DEF    = 3;
    localparam int SCORE_W_DEF       = 14;
    localparam int MAX_SCORE_DEF     = 9999;
    localparam int HART_POINTS_DEF   = 10;
    localparam int DEATH_FRAMES_DEF  = 60;
    localparam int INVULN_FRAMES_DEF = 90;

    // Load wins over a step; a step on a zero count holds at zero.
    function automatic logic [TIMER_W-1:0] timer_next(
        input logic [TIMER_W-1:0] count,
        input logic               load,
        input logic [TIMER_W-1:0] load_val,
        input logic               step
    );
        logic [TIMER_W-1:0] nxt;
        if (load) begin
            nxt = load_val;
        end else if (step && (count != {TIMER_W{1'b0}})) begin
            nxt = count - {{(TIMER_W-1){1'b0}}, 1'b1};
        end else begin
            nxt = count;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Loadable frame down-counter.
//   clk, resetN : clock, asynchronous active-low reset
//   load        : load count with load_val (wins over tick)
//   load_val    : value to load
//   tick        : per-frame tick (startOfFrame)
//   en          : tick qualifier
//   count       : current count
//   done        : strobe on the final tick; a count of 0 or 1 finishes on
//                 the next enabled tick, so a zero load behaves like one.
module frame_timer
    import game_pkg::*;
(
    input  logic               clk,
    input  logic               resetN,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               tick,
    input  logic               en,
    output logic [TIMER_W-1:0] count,
    output logic               done
);

    logic step_s;

    assign step_s = tick & en;
    assign done   = step_s & ~load &
                    (count <= {{(TIMER_W-1){1'b0}}, 1'b1});

    // Count register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= {TIMER_W{1'b0}};
        end else begin
            count <= timer_next(count, load, load_val, step_s);
        end
    end

endmodule

// File: rtl/game_state_manager.sv
// Game progression: score, lives, death/respawn timing, invulnerability
// blink and game-over, driven by per-frame collision pulses.
//   clk, resetN            : clock, asynchronous active-low reset
//   startOfFrame           : one-cycle frame pulse
//   start_key              : start button level (rising edge used)
//   SingleHitPulse         : collision event qualifier
//   strike                 : smiley-ghost overlap
//   collision_Smiley_Hart  : smiley-hart overlap
//   score, lives, state    : progression outputs
//   freeze                 : high except in PLAY
//   smiley_visible         : smiley draw enable (blinks while invulnerable)
//   respawn                : one-cycle pulse on DYING->PLAY
//   game_over              : high in GAME_OVER
module game_state_manager
    import game_pkg::*;
#(
    parameter int LIVES_INIT    = LIVES_INIT_DEF,
    parameter int SCORE_W       = SCORE_W_DEF,
    parameter int MAX_SCORE     = MAX_SCORE_DEF,
    parameter int HART_POINTS   = HART_POINTS_DEF,
    parameter int DEATH_FRAMES  = DEATH_FRAMES_DEF,
    parameter int INVULN_FRAMES = INVULN_FRAMES_DEF
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               start_key,
    input  logic               SingleHitPulse,
    input  logic               strike,
    input  logic               collision_Smiley_Hart,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         lives,
    output logic [1:0]         state,
    output logic               freeze,
    output logic               smiley_visible,
    output logic               respawn,
    output logic               game_over
);

    game_state_e        state_r, state_nx_s;
    logic               start_key_d_r;
    logic               start_rise_s;
    logic [SCORE_W-1:0] score_nx_s;
    logic [2:0]         lives_nx_s;
    logic               respawn_nx_s;
    logic [SCORE_W:0]   score_sum_s;

    logic               death_load_s, death_done_s;
    logic [TIMER_W-1:0] death_count_unused;
    logic               invuln_load_s, invuln_step_s, invuln_done_unused;
    logic [TIMER_W-1:0] invuln_val_s, invuln_count_s, invuln_nx_s;
    logic               visible_nx_s;

    assign start_rise_s  = start_key & ~start_key_d_r;
    assign invuln_step_s = startOfFrame & (state_r == ST_PLAY);
    assign score_sum_s   = {1'b0, score} + (SCORE_W+1)'(HART_POINTS);
    assign state         = state_r;

    frame_timer u_death_timer (
        .clk      (clk),
        .resetN   (resetN),
        .load     (death_load_s),
        .load_val (TIMER_W'(DEATH_FRAMES)),
        .tick     (startOfFrame),
        .en       (state_r == ST_DYING),
        .count    (death_count_unused),
        .done     (death_done_s)
    );

    frame_timer u_invuln_timer (
        .clk      (clk),
        .resetN   (resetN),
        .load     (invuln_load_s),
        .load_val (invuln_val_s),
        .tick     (startOfFrame),
        .en       (state_r == ST_PLAY),
        .count    (invuln_count_s),
        .done     (invuln_done_unused)
    );

    // Next-state, score/lives update and timer load decisions
    always_comb begin
        state_nx_s    = state_r;
        score_nx_s    = score;
        lives_nx_s    = lives;
        respawn_nx_s  = 1'b0;
        death_load_s  = 1'b0;
        invuln_load_s = 1'b0;
        invuln_val_s  = {TIMER_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (start_rise_s) begin
                    state_nx_s    = ST_PLAY;
                    score_nx_s    = {SCORE_W{1'b0}};
                    lives_nx_s    = 3'(LIVES_INIT);
                    invuln_load_s = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (SingleHitPulse) begin
                    // A strike only kills when not invulnerable; otherwise a
                    // coincident hart overlap still scores.
                    if (strike && (invuln_count_s == {TIMER_W{1'b0}}) &&
                        (lives != 3'd0)) begin
                        state_nx_s   = ST_DYING;
                        lives_nx_s   = lives - 3'd1;
                        death_load_s = 1'b1;
                    end else if (collision_Smiley_Hart) begin
                        if (score_sum_s > (SCORE_W+1)'(MAX_SCORE)) begin
                            score_nx_s = SCORE_W'(MAX_SCORE);
                        end else begin
                            score_nx_s = score_sum_s[SCORE_W-1:0];
                        end
                    end else begin
                        score_nx_s = score;
                    end
                end else begin
                    state_nx_s = ST_PLAY;
                end
            end
            ST_DYING: begin
                if (death_done_s) begin
                    if (lives == 3'd0) begin
                        state_nx_s = ST_GAME_OVER;
                    end else begin
                        state_nx_s    = ST_PLAY;
                        respawn_nx_s  = 1'b1;
                        invuln_load_s = 1'b1;
                        invuln_val_s  = TIMER_W'(INVULN_FRAMES);
                    end
                end else begin
                    state_nx_s = ST_DYING;
                end
            end
            ST_GAME_OVER: begin
                if (start_rise_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_GAME_OVER;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Visibility computed from next state and next invulnerability count
    always_comb begin
        invuln_nx_s  = timer_next(invuln_count_s, invuln_load_s, invuln_val_s,
                                  invuln_step_s);
        visible_nx_s = 1'b1;
        if (state_nx_s == ST_GAME_OVER) begin
            visible_nx_s = 1'b0;
        end else if ((state_nx_s == ST_DYING) ||
                     (invuln_nx_s == {TIMER_W{1'b0}})) begin
            visible_nx_s = 1'b1;
        end else begin
            visible_nx_s = invuln_nx_s[3];
        end
    end

    // State, score, lives and registered outputs
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r        <= ST_IDLE;
            start_key_d_r  <= 1'b0;
            score          <= {SCORE_W{1'b0}};
            lives          <= 3'(LIVES_INIT);
            freeze         <= 1'b1;
            smiley_visible <= 1'b1;
            respawn        <= 1'b0;
            game_over      <= 1'b0;
        end else begin
            state_r        <= state_nx_s;
            start_key_d_r  <= start_key;
            score          <= score_nx_s;
            lives          <= lives_nx_s;
            freeze         <= (state_nx_s != ST_PLAY);
            smiley_visible <= visible_nx_s;
            respawn        <= respawn_nx_s;
            game_over      <= (state_nx_s == ST_GAME_OVER);
        end
    end

endmodule
